mptw_req_arbiter: RTL and testbench

MPTW_REQ_ARBITER -- requirements
Module: mptw_req_arbiter

---
 rtl/mptw_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_mptw_req_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mptw_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mptw_req_arbiter
// Brief    : Round-robin requester arbiter for the walker pipeline. It limits
//            outstanding transactions and sequences a drain/flush handshake.
//            Optional macro MPTW_ARB_PERF_EN adds per-requester grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module mptw_req_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic [$clog2(NUM_REQ)-1:0]    m_id_o,
    input  logic                          rsp_done_i,
    input  logic                          flush_i,
    output logic                          flush_req_o,
    input  logic                          flush_ack_i,
    output logic                          busy_o
`ifdef MPTW_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_cnt_o
`endif
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_IW1 = c_IDW + 1;
    localparam int c_CW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_CW-1:0]  r_outst;
    logic [c_CW-1:0]  w_outst_nxt;
    logic [c_IDW-1:0] r_rr_ptr;
    logic [c_IDW-1:0] r_gnt_idx;
    logic             r_lock;

    logic             w_found;
    logic [c_IDW-1:0] w_sel;
    logic [c_IW1-1:0] w_idx;
    logic [c_IDW-1:0] w_gnt;
    logic             w_can_grant;
    logic             w_mvalid;
    logic             w_hs;
    logic             w_dec;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + c_IW1'(i);
            if (w_idx >= c_IW1'(NUM_REQ)) begin
                w_idx = w_idx - c_IW1'(NUM_REQ);
            end
            if (!w_found && req_valid_i[w_idx[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[c_IDW-1:0];
            end
        end
    end

    // A flush request blocks fresh grants so the FSM can leave RUN cleanly.
    assign w_can_grant = (r_state == c_RUN) && !flush_i &&
                         (r_outst < c_CW'(MAX_OUTSTANDING));
    assign w_gnt       = r_lock ? r_gnt_idx : w_sel;
    assign w_mvalid    = r_lock | (w_can_grant & w_found);
    assign w_hs        = w_mvalid & m_ready_i;
    assign w_dec       = rsp_done_i & (r_outst != '0);

    assign m_valid_o   = w_mvalid;
    assign m_id_o      = w_mvalid ? w_gnt : '0;
    assign m_data_o    = w_mvalid ? req_data_i[w_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign req_ready_o = w_hs ? (NUM_REQ'(1) << w_gnt) : '0;
    assign flush_req_o = (r_state == c_FLUSH);
    assign busy_o      = (r_state != c_RUN) || (r_outst != '0);

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_hs && !w_dec) begin
            w_outst_nxt = r_outst + 1'b1;
        end else if (!w_hs && w_dec) begin
            w_outst_nxt = r_outst - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN:   if (flush_i && !r_lock)    w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_outst_nxt == '0)     w_state_nxt = c_FLUSH;
            c_FLUSH: if (flush_ack_i)           w_state_nxt = c_DONE;
            c_DONE:  if (!flush_i)              w_state_nxt = c_RUN;
            default:                            w_state_nxt = c_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_RUN;
            r_outst   <= '0;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_lock    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            r_lock  <= w_mvalid & !m_ready_i;
            if (w_mvalid && !m_ready_i) begin
                r_gnt_idx <= w_gnt;
            end
            if (w_hs) begin
                r_rr_ptr <= (w_gnt == c_IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
            end
        end
    end

`ifdef MPTW_ARB_PERF_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf
        logic [15:0] r_cnt;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (r_state == c_FLUSH && flush_ack_i) begin
                r_cnt <= '0;
            end else if (w_hs && (w_gnt == c_IDW'(k)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign grant_cnt_o[k*16 +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mptw_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mptw_req_arbiter
// Brief    : Directed self-checking bench for mptw_req_arbiter (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mptw_req_arbiter;

    localparam int c_NR = 2;
    localparam int c_DW = 32;

    logic                 clk;
    logic                 rst_n;
    logic [c_NR-1:0]      req_valid;
    logic [c_NR*c_DW-1:0] req_data;
    logic [c_NR-1:0]      req_ready;
    logic                 m_valid;
    logic                 m_ready;
    logic [c_DW-1:0]      m_data;
    logic [0:0]           m_id;
    logic                 rsp_done;
    logic                 flush;
    logic                 flush_req;
    logic                 flush_ack;
    logic                 busy;

    int n_vec;
    int n_err;
    int hs_cnt;

    mptw_req_arbiter #(
        .NUM_REQ         (c_NR),
        .DATA_WIDTH      (c_DW),
        .MAX_OUTSTANDING (4)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_id_o      (m_id),
        .rsp_done_i  (rsp_done),
        .flush_i     (flush),
        .flush_req_o (flush_req),
        .flush_ack_i (flush_ack),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = {32'hBBBB_0001, 32'hAAAA_0000};
        m_ready   = 1'b0;
        rsp_done  = 1'b0;
        flush     = 1'b0;
        flush_ack = 1'b0;
        repeat (2) tick();
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_m_id", 32'(m_id), 32'd0);
        check_val("rst_m_data", m_data, 32'd0);
        check_val("rst_flush_req", 32'(flush_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Alternating grants with responses echoing handshakes.
        req_valid = 2'b11; m_ready = 1'b1; rsp_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("rr_id", 32'(m_id), 32'(i % 2));
            check_val("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val("rr_data", m_data, (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
            tick();
        end
        req_valid = 2'b00;
        tick();
        rsp_done = 1'b0;
        #1;
        check_val("rr_idle_busy", 32'(busy), 32'd0);

        // Outstanding limit: four handshakes, then stall until a response.
        req_valid = 2'b11; m_ready = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (m_valid && m_ready) hs_cnt++;
            tick();
        end
        check_val("max_hs_count", 32'(hs_cnt), 32'd4);
        check_val("max_stall_valid", 32'(m_valid), 32'd0);
        check_val("max_busy", 32'(busy), 32'd1);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        check_val("max_resume_valid", 32'(m_valid), 32'd1);
        check_val("max_resume_id", 32'(m_id), 32'd0);
        tick();
        req_valid = 2'b00; rsp_done = 1'b1;
        repeat (4) tick();
        rsp_done = 1'b0;
        #1;
        check_val("max_drained_busy", 32'(busy), 32'd0);

        // Grant lock: requester 1 stalled while requester 0 competes.
        req_valid = 2'b10; m_ready = 1'b0;
        #1;
        check_val("lock_first_id", 32'(m_id), 32'd1);
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("lock_valid", 32'(m_valid), 32'd1);
            check_val("lock_id", 32'(m_id), 32'd1);
            check_val("lock_data", m_data, 32'hBBBB_0001);
            check_val("lock_ready", 32'(req_ready), 32'd0);
            tick();
        end
        m_ready = 1'b1;
        #1;
        check_val("lock_release_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00; m_ready = 1'b0;

        // Flush with two transactions outstanding.
        flush = 1'b1; req_valid = 2'b11;
        #1;
        check_val("fl_no_grant_run", 32'(m_valid), 32'd0);
        tick();
        check_val("fl_drain_valid", 32'(m_valid), 32'd0);
        check_val("fl_drain_busy", 32'(busy), 32'd1);
        check_val("fl_drain_req", 32'(flush_req), 32'd0);
        rsp_done = 1'b1;
        tick();
        check_val("fl_drain1_req", 32'(flush_req), 32'd0);
        tick();
        rsp_done = 1'b0;
        #1;
        check_val("fl_flush_req", 32'(flush_req), 32'd1);
        tick();
        check_val("fl_flush_hold", 32'(flush_req), 32'd1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        #1;
        check_val("fl_done_req", 32'(flush_req), 32'd0);
        check_val("fl_done_busy", 32'(busy), 32'd1);
        check_val("fl_done_valid", 32'(m_valid), 32'd0);
        tick();
        check_val("fl_done_stay", 32'(busy), 32'd1);
        flush = 1'b0;
        tick();
        check_val("fl_run_busy", 32'(busy), 32'd0);
        check_val("fl_run_valid", 32'(m_valid), 32'd1);
        check_val("fl_rr_kept_id", 32'(m_id), 32'd1);

        // Simultaneous handshake and response at three outstanding.
        m_ready = 1'b1;
        repeat (3) tick();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        check_val("sim_still_room", 32'(m_valid), 32'd1);
        check_val("sim_id", 32'(m_id), 32'd1);
        tick();
        check_val("sim_now_full", 32'(m_valid), 32'd0);
        req_valid = 2'b00; rsp_done = 1'b1;
        repeat (6) tick();
        rsp_done = 1'b0;
        #1;
        check_val("underflow_busy", 32'(busy), 32'd0);
        req_valid = 2'b11; m_ready = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (m_valid && m_ready) hs_cnt++;
            tick();
        end
        check_val("underflow_hs_count", 32'(hs_cnt), 32'd4);
        req_valid = 2'b00; m_ready = 1'b0; rsp_done = 1'b1;
        repeat (4) tick();
        rsp_done = 1'b0;

        // Asynchronous reset in the middle of FLUSH.
        flush = 1'b1;
        tick();
        tick();
        check_val("rstfl_flush_req", 32'(flush_req), 32'd1);
        req_valid = 2'b11;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rstfl_req_low", 32'(flush_req), 32'd0);
        check_val("rstfl_busy", 32'(busy), 32'd0);
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rstfl_grant_valid", 32'(m_valid), 32'd1);
        check_val("rstfl_grant_id", 32'(m_id), 32'd0);
        tick();
        check_val("rstfl_no_flush_req", 32'(flush_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
